seg7_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed 7-segment display controller with per-digit registers, a hex-decode or raw-segment mode per digit, and PWM brightness control. It runs in a single clock domain and uses a prescaler tick-enable; it does not create a derived clock. It sits between a host write port and the board's display pins. Output polarity is selectable for common-anode or common-cathode boards.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scan_ctrl_if.sv | 14 +
 rtl/seg7_tick_gen.sv | 22 ++
 rtl/seg7_scan_ctrl.sv | 105 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display controller.
package seg7_pkg;

  // Active-high glyphs, bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       raw;
    logic       dp;
    logic [6:0] data;
  } seg7_entry_t;

  localparam seg7_entry_t SEG7_BLANK = '{raw: 1'b1, dp: 1'b0, data: 7'd0};

  // Returns {dp, seg} for one stored entry.
  function automatic logic [7:0] seg7_decode(seg7_entry_t e);
    if (e.raw) return {e.dp, e.data};
    return {e.dp, HEX_FONT[e.data[3:0]]};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host write port of the 7-segment scan controller.
interface seg7_scan_ctrl_if #(
  parameter int ADDR_W = 2
);
  // Valid-only port: wr_en qualifies wr_addr/wr_data/wr_raw for exactly one
  // clk; there is no ready, every strobed write is taken on that edge.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_raw;

  modport master (output wr_en, wr_addr, wr_data, wr_raw);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_raw);
endinterface

// File: rtl/seg7_tick_gen.sv
// Prescaler: one-cycle tick-enable every DIV clk cycles (DIV >= 1).
module seg7_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with hex/raw entries and PWM brightness.
// Define SEG7_LZB_EN to build in leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SCAN_FREQ  = 1000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_ctrl_if.slave       wr,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [6:0]            seg,
  output logic                  dp
);
  import seg7_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int P_RAW = CLK_FREQ / (SCAN_FREQ * (2 ** BRIGHT_W));
  localparam int P     = (P_RAW < 1) ? 1 : P_RAW;

  logic                  tick;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic [IDX_W-1:0]      scan_idx;
  seg7_entry_t           entry_q [NUM_DIGITS];
  seg7_entry_t           cur;
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic                  suppress;
  logic                  lit;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] en_q;

  seg7_tick_gen #(.DIV(P)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // One digit slot is a full PWM period; the digit advances on the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt  <= '0;
      scan_idx <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1)
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= SEG7_BLANK;
    end else if (wr.wr_en && (int'(wr.wr_addr) < NUM_DIGITS)) begin
      entry_q[wr.wr_addr] <= '{raw: wr.wr_raw, dp: wr.wr_data[7], data: wr.wr_data[6:0]};
    end
  end

  always_comb begin
    cur               = entry_q[scan_idx];
    {cur_dp, cur_seg} = seg7_decode(cur);
  end

`ifdef SEG7_LZB_EN
  // zero_run[d]: digit d and every digit above it are hex zeros without dp.
  logic [NUM_DIGITS-1:0] zero_run;
  logic                  run;

  always_comb begin
    run      = 1'b1;
    zero_run = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      run = run && !entry_q[d].raw && !entry_q[d].dp && (entry_q[d].data[3:0] == 4'd0);
      zero_run[d] = run;
    end
  end

  assign suppress = (scan_idx != '0) && zero_run[scan_idx];
`else
  assign suppress = 1'b0;
`endif

  assign lit = (pwm_cnt < brightness) && ((cur_seg != 7'd0) || cur_dp) && !suppress;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      en_q  <= '0;
    end else begin
      seg_q <= cur_seg;
      dp_q  <= cur_dp;
      en_q  <= lit ? (NUM_DIGITS'(1) << scan_idx) : '0;
    end
  end

  assign seg      = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp       = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign digit_en = (ACTIVE_LOW != 0) ? ~en_q  : en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: reference model pushes expected pins per
// clk, a negedge monitor pops and compares. Honours SEG7_LZB_EN if defined.
module tb_seg7_scan_ctrl;

  localparam int ND   = 4;
  localparam int P    = 4;   // 1600 / (100 * 2^2)
  localparam int NPWM = 4;

  logic       clk;
  logic       rst;
  logic [1:0] brightness;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_ctrl_if #(.ADDR_W(2)) wr_if ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .CLK_FREQ   (1600),
    .SCAN_FREQ  (100),
    .BRIGHT_W   (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .brightness (brightness),
    .digit_en   (digit_en),
    .seg        (seg),
    .dp         (dp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  font [16];
  logic        m_raw  [ND];
  logic [7:0]  m_data [ND];
  int unsigned cyc;
  logic [11:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  function automatic bit lzb_hidden(int dig);
`ifdef SEG7_LZB_EN
    if (dig == 0) return 1'b0;
    for (int k = dig; k < ND; k++)
      if (m_raw[k] || m_data[k][7] || (m_data[k][3:0] != 4'd0)) return 1'b0;
    return 1'b1;
`else
    return (dig < 0);
`endif
  endfunction

  // Pins {digit_en, seg, dp} after an edge, given cycles elapsed since reset.
  function automatic logic [11:0] model_pins(int unsigned c, logic [1:0] br);
    int unsigned pwm = (c / P) % NPWM;
    int          dig = int'((c / (P * NPWM)) % ND);
    logic [6:0]  s;
    logic        d;
    logic [3:0]  en;
    logic [7:0]  v;
    v  = m_data[dig];
    s  = m_raw[dig] ? v[6:0] : font[v[3:0]];
    d  = v[7];
    en = 4'b0000;
    if ((pwm < br) && ((s != 7'd0) || d) && !lzb_hidden(dig)) en[dig] = 1'b1;
    return ~{en, s, d};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ND; i++) begin
        m_raw[i]  = 1'b1;
        m_data[i] = 8'h00;
      end
      cyc = 0;
    end else begin
      exp_q.push_back(model_pins(cyc, brightness));
      if (wr_if.wr_en) begin
        m_raw[wr_if.wr_addr]  = wr_if.wr_raw;
        m_data[wr_if.wr_addr] = wr_if.wr_data;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t: got en=%b seg=%h dp=%b, expected en=%b seg=%h dp=%b",
                  name, $time, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      check("reset_pins", {digit_en, seg, dp}, 12'hFFF);
    end else if (exp_q.size() > 0) begin
      check("scan_pins", {digit_en, seg, dp}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_write(logic [1:0] addr, logic [7:0] data, logic raw);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = addr;
    wr_if.wr_data = data;
    wr_if.wr_raw  = raw;
    idle(1);
    wr_if.wr_en = 1'b0;
  endtask

  task automatic load_hex4(logic [3:0] d3, logic [3:0] d2, logic [3:0] d1, logic [3:0] d0);
    do_write(2'd3, {4'h0, d3}, 1'b0);
    do_write(2'd2, {4'h0, d2}, 1'b0);
    do_write(2'd1, {4'h0, d1}, 1'b0);
    do_write(2'd0, {4'h0, d0}, 1'b0);
  endtask

  task automatic pulse_reset(int n);
    rst = 1'b0;
    idle(n);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b0;
    brightness    = 2'd0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = 2'd0;
    wr_if.wr_data = 8'h00;
    wr_if.wr_raw  = 1'b0;
    @(posedge clk);
    #2;
    idle(3);
    rst = 1'b1;

    // Blank display after reset, two full frames.
    idle(128);

    // Hex 3 with dp on digit 0, then raw glyph on digit 2.
    brightness = 2'd3;
    do_write(2'd0, 8'h83, 1'b0);
    idle(64);
    do_write(2'd2, 8'h3F, 1'b1);
    idle(64);

    // Dark at brightness 0, then minimal on-time.
    load_hex4(4'h8, 4'hA, 4'h7, 4'hF);
    brightness = 2'd0;
    idle(64);
    brightness = 2'd1;
    idle(64);

    // Scan order with distinct digits.
    brightness = 2'd3;
    load_hex4(4'h4, 4'h3, 4'h2, 4'h1);
    idle(80);

    // Leading zeros: digits 3..0 = 0,0,5,0.
    load_hex4(4'h0, 4'h0, 4'h5, 4'h0);
    idle(64);

    // Reset mid-frame, then scanning restarts from digit 0.
    idle(23);
    pulse_reset(3);
    load_hex4(4'h0, 4'h9, 4'h0, 4'hC);
    idle(70);

    // Randomized writes and brightness changes.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] d;
        d = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        do_write(2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1) == 0 ? 0 : ($urandom_range(0, 2) == 0)));
      end else begin
        idle(1);
      end
      if (i == 1300) pulse_reset(2);
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
